// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the unified memory arbiter.
//   state_t : bring-up / run sequencing states
//   tag_t   : owner of the read response expected on the next cycle
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DM   = 2'd2
    } tag_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arb_if
// Bundles every non-clock/reset signal of the arbiter:
//   loader    : load_en, load_data
//   fetch     : if_req, if_addr -> if_rdata, if_valid, if_stall
//   data      : dm_rd, dm_wr, dm_addr, dm_wdata -> dm_rdata, dm_valid, dm_stall
//   memory    : mem_rd, mem_wr, mem_addr, mem_wdata <- mem_rdata
//   status    : load_busy, load_count, err
// slave  = arbiter side, master = CPU / memory environment side.
// -----------------------------------------------------------------------------
interface mem_arb_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              load_en;
    logic [DATA_W-1:0] load_data;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              load_busy;
    logic [ADDR_W-1:0] load_count;
    logic              err;

    modport slave (
        input  load_en, load_data, if_req, if_addr, dm_rd, dm_wr, dm_addr,
               dm_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_rd, mem_wr, mem_addr, mem_wdata, load_busy, load_count, err
    );

    modport master (
        output load_en, load_data, if_req, if_addr, dm_rd, dm_wr, dm_addr,
               dm_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_rd, mem_wr, mem_addr, mem_wdata, load_busy, load_count, err
    );

endinterface

// File: rtl/unified_mem_arbiter_load_addr_counter.sv
// -----------------------------------------------------------------------------
// load_addr_counter
// Program-load write address generator.
//   clk, Reset : clock, synchronous active-low reset
//   restart    : first word of a new load; address forced to LOAD_BASE
//   step       : a word is written this cycle; advance
//   addr       : address for the word written this cycle
//   count      : words written since the last restart, saturating at LOAD_DEPTH
// -----------------------------------------------------------------------------
module load_addr_counter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_DEPTH = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              restart,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] count
);

    localparam logic [ADDR_W-1:0] BASE_V  = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] LAST_V  = ADDR_W'(LOAD_BASE + LOAD_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(LOAD_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_V   = ADDR_W'(1);

    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] count_r;

    // The restart word goes to LOAD_BASE without waiting a cycle for a reload.
    always_comb begin
        if (restart) begin
            addr = BASE_V;
        end else begin
            addr = cnt_r;
        end
    end

    assign count = count_r;

    // Next write address (wrapping) and saturating word count.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            cnt_r   <= BASE_V;
            count_r <= {ADDR_W{1'b0}};
        end else if (step) begin
            cnt_r   <= (addr == LAST_V) ? BASE_V : addr + ONE_V;
            if (restart) begin
                count_r <= ONE_V;
            end else if (count_r == DEPTH_V) begin
                count_r <= DEPTH_V;
            end else begin
                count_r <= count_r + ONE_V;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-ported, one-cycle-latency memory between the program
// loader, instruction fetch and data access, and sequences IDLE -> LOAD -> RUN.
//   clk   : rising-edge clock
//   Reset : synchronous active-low reset
//   bus   : mem_arb_if.slave (loader, fetch, data, memory and status signals)
// Grants are combinational so the winning access reaches the memory in the
// same cycle; the read response is steered by a tag registered at grant time.
// -----------------------------------------------------------------------------
module unified_mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_DEPTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic      clk,
    input logic      Reset,
    mem_arb_if.slave bus
);

    localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    state_t              state_r;
    state_t              state_nxt_s;
    tag_t                tag_r;
    tag_t                tag_nxt_s;
    logic [BURST_W-1:0]  burst_r;
    logic [BURST_W-1:0]  burst_nxt_s;
    logic [DATA_W-1:0]   if_hold_r;
    logic [DATA_W-1:0]   dm_hold_r;
    logic                err_r;

    logic                load_wr_s;
    logic                run_s;
    logic                dm_req_s;
    logic                grant_dm_s;
    logic                grant_if_s;
    logic                if_valid_s;
    logic                dm_valid_s;
    logic                load_restart_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic [ADDR_W-1:0]   load_count_s;

    logic                mem_rd_s;
    logic                mem_wr_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    // Any cycle with load_en is a load write, including the one that leaves
    // IDLE/RUN, so the first word lands at LOAD_BASE with no dead cycle.
    assign load_wr_s      = Reset & bus.load_en;
    assign run_s          = Reset & ~bus.load_en & (state_r == RUN);
    assign dm_req_s       = bus.dm_rd | bus.dm_wr;
    assign load_restart_s = (state_r != LOAD);

    load_addr_counter #(
        .ADDR_W     (ADDR_W),
        .LOAD_BASE  (LOAD_BASE),
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_load_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .restart (load_restart_s),
        .step    (load_wr_s),
        .addr    (load_addr_s),
        .count   (load_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: load_en always pulls towards LOAD, its release starts RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = bus.load_en ? LOAD : IDLE;
            LOAD:    state_nxt_s = bus.load_en ? LOAD : RUN;
            RUN:     state_nxt_s = bus.load_en ? LOAD : RUN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: grant decision and the memory command it produces.
    always_comb begin
        grant_dm_s  = 1'b0;
        grant_if_s  = 1'b0;
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        tag_nxt_s   = TAG_NONE;
        burst_nxt_s = {BURST_W{1'b0}};

        // Data wins unless it has used up its burst while fetch is waiting.
        if (run_s) begin
            if (dm_req_s && !((burst_r == BURST_MAX) && bus.if_req)) begin
                grant_dm_s = 1'b1;
            end else if (bus.if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_dm_s = 1'b0;
            end
        end else begin
            grant_dm_s = 1'b0;
        end

        // A combined read+write performs the write only.
        if (load_wr_s) begin
            mem_wr_s    = 1'b1;
            mem_addr_s  = load_addr_s;
            mem_wdata_s = bus.load_data;
        end else if (grant_dm_s) begin
            mem_rd_s    = bus.dm_rd & ~bus.dm_wr;
            mem_wr_s    = bus.dm_wr;
            mem_addr_s  = bus.dm_addr;
            mem_wdata_s = bus.dm_wdata;
        end else if (grant_if_s) begin
            mem_rd_s    = 1'b1;
            mem_addr_s  = bus.if_addr;
        end else begin
            mem_rd_s    = 1'b0;
        end

        if (grant_if_s) begin
            tag_nxt_s = TAG_IF;
        end else if (grant_dm_s && bus.dm_rd && !bus.dm_wr) begin
            tag_nxt_s = TAG_DM;
        end else begin
            tag_nxt_s = TAG_NONE;
        end

        // Saturate so a long data-only run still reports a full burst.
        if (grant_dm_s) begin
            burst_nxt_s = (burst_r == BURST_MAX) ? BURST_MAX : burst_r + BURST_ONE;
        end else begin
            burst_nxt_s = {BURST_W{1'b0}};
        end
    end

    // A response is dropped if load_en rises while it is in flight.
    assign if_valid_s = Reset & ~bus.load_en & (tag_r == TAG_IF);
    assign dm_valid_s = Reset & ~bus.load_en & (tag_r == TAG_DM);

    // Response tag, burst count, held read data and sticky error.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            tag_r     <= TAG_NONE;
            burst_r   <= {BURST_W{1'b0}};
            if_hold_r <= {DATA_W{1'b0}};
            dm_hold_r <= {DATA_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            tag_r   <= tag_nxt_s;
            burst_r <= burst_nxt_s;
            if (if_valid_s) begin
                if_hold_r <= bus.mem_rdata;
            end
            if (dm_valid_s) begin
                dm_hold_r <= bus.mem_rdata;
            end
            if (bus.dm_rd && bus.dm_wr) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.mem_rd     = mem_rd_s;
    assign bus.mem_wr     = mem_wr_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.if_valid   = if_valid_s;
    assign bus.dm_valid   = dm_valid_s;
    assign bus.if_rdata   = if_valid_s ? bus.mem_rdata : if_hold_r;
    assign bus.dm_rdata   = dm_valid_s ? bus.mem_rdata : dm_hold_r;
    assign bus.if_stall   = ~run_s | (bus.if_req & ~grant_if_s);
    assign bus.dm_stall   = ~run_s | (dm_req_s & ~grant_dm_s);
    assign bus.load_busy  = (state_r == LOAD);
    assign bus.load_count = load_count_s;
    assign bus.err        = err_r;

endmodule
